j1_stack: RTL and testbench

- Parametrised data/return stack for the next-generation J1 core.
- Replaces the fixed 16x16 register-file stack with a cached top-of-stack register plus circular storage.
- Takes J1-style signed stack deltas (+1/0/-1/-2), keeps an occupancy count, and adds full/empty status, sticky overflow/underflow flags and a high-water mark.
- One instance serves as the data stack, a second as the return stack.

---
 rtl/j1_pkg.sv | 15 +
 rtl/stack_ram_2r1w.sv | 29 ++
 rtl/j1_stack.sv | 135 +++++++++++++
 tb/tb_j1_stack.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/j1_pkg.sv
// Shared definitions for the J1 stacks: stack delta encodings and the
// decoded stack operation the core decoder hands to each stack instance.
package j1_pkg;

    localparam logic [1:0] D_NONE = 2'b00;
    localparam logic [1:0] D_PUSH = 2'b01;
    localparam logic [1:0] D_POP1 = 2'b11;
    localparam logic [1:0] D_POP2 = 2'b10;

    typedef struct packed {
        logic [1:0] delta;
        logic       tos_we;
    } stack_op_t;

endpackage

// File: rtl/stack_ram_2r1w.sv
// Circular stack storage: one synchronous write port, two asynchronous read
// ports. Contents are deliberately not reset.
module stack_ram_2r1w #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa,
    input  logic [WIDTH-1:0] i_wd,
    input  logic [AW-1:0]    i_ra0,
    input  logic [AW-1:0]    i_ra1,
    output logic [WIDTH-1:0] o_rd0,
    output logic [WIDTH-1:0] o_rd1
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd0 = r_mem[i_ra0];
    assign o_rd1 = r_mem[i_ra1];

endmodule

// File: rtl/j1_stack.sv
// J1 data/return stack: registered TOS cache over circular storage, with
// occupancy count, full/empty status, sticky overflow/underflow and high-water mark.
module j1_stack
    import j1_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       delta,
    input  logic             tos_we,
    input  logic [WIDTH-1:0] wd,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf,
    output logic [CW-1:0]    hwm
);

    localparam int            SPW    = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [SPW-1:0]   r_sp;
    logic [WIDTH-1:0] r_tos;
    logic [CW-1:0]    r_depth;
    logic [CW-1:0]    r_hwm;
    logic             r_ovf;
    logic             r_unf;

    stack_op_t        w_op;
    logic [SPW-1:0]   w_sp_nxt;
    logic [WIDTH-1:0] w_tos_nxt;
    logic [CW-1:0]    w_depth_nxt;
    logic [CW-1:0]    w_hwm_nxt;
    logic             w_push;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [WIDTH-1:0] w_nos;
    logic [WIDTH-1:0] w_third;

    // Push writes the old TOS at the next sp, so the write address is w_sp_nxt.
    stack_ram_2r1w #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk   (clk),
        .i_we  (en && !reset && w_push),
        .i_wa  (w_sp_nxt),
        .i_wd  (r_tos),
        .i_ra0 (r_sp),
        .i_ra1 (r_sp - SPW'(1)),
        .o_rd0 (w_nos),
        .o_rd1 (w_third)
    );

    always_comb begin
        w_op        = '{delta: delta, tos_we: tos_we};
        w_sp_nxt    = r_sp;
        w_tos_nxt   = w_op.tos_we ? wd : r_tos;
        w_depth_nxt = r_depth;
        w_push      = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (w_op.delta)
            D_PUSH: begin
                w_push   = 1'b1;
                w_sp_nxt = r_sp + SPW'(1);
                if (r_depth == DEPTH_C) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_depth_nxt = r_depth + CW'(1);
                end
            end
            D_POP1: begin
                w_sp_nxt  = r_sp - SPW'(1);
                w_tos_nxt = w_op.tos_we ? wd : w_nos;
                if (r_depth == '0) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_depth_nxt = r_depth - CW'(1);
                end
            end
            D_POP2: begin
                w_sp_nxt  = r_sp - SPW'(2);
                w_tos_nxt = w_op.tos_we ? wd : w_third;
                if (r_depth < CW'(2)) begin
                    w_unf_set   = 1'b1;
                    w_depth_nxt = '0;
                end else begin
                    w_depth_nxt = r_depth - CW'(2);
                end
            end
            default: ;
        endcase
        w_hwm_nxt = (w_depth_nxt > r_hwm) ? w_depth_nxt : r_hwm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp    <= '0;
            r_tos   <= '0;
            r_depth <= '0;
            r_hwm   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (en) begin
                r_sp    <= w_sp_nxt;
                r_tos   <= w_tos_nxt;
                r_depth <= w_depth_nxt;
                r_hwm   <= w_hwm_nxt;
            end
            // A new error in the same cycle as clr_err leaves the flag set.
            r_ovf <= (r_ovf && !clr_err) || (en && w_ovf_set);
            r_unf <= (r_unf && !clr_err) || (en && w_unf_set);
        end
    end

    assign tos   = r_tos;
    assign nos   = w_nos;
    assign depth = r_depth;
    assign hwm   = r_hwm;
    assign ovf   = r_ovf;
    assign unf   = r_unf;
    assign empty = (r_depth == '0);
    assign full  = (r_depth == DEPTH_C);

endmodule

// File: tb/tb_j1_stack.sv
// Directed bench for j1_stack (WIDTH=16, DEPTH=16) with hand-computed expectations.
module tb_j1_stack;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  delta;
    logic        tos_we;
    logic [15:0] wd;
    logic        clr_err;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic [4:0]  hwm;

    int errors = 0;
    int checks = 0;

    j1_stack #(.WIDTH(16), .DEPTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .delta   (delta),
        .tos_we  (tos_we),
        .wd      (wd),
        .clr_err (clr_err),
        .tos     (tos),
        .nos     (nos),
        .depth   (depth),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf),
        .hwm     (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic e, input logic [1:0] d, input logic we,
                      input logic [15:0] w, input logic c);
        en      = e;
        delta   = d;
        tos_we  = we;
        wd      = w;
        clr_err = c;
        step();
        en      = 1'b0;
        delta   = 2'b00;
        tos_we  = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; delta = 2'b00; tos_we = 1'b0; wd = '0; clr_err = 1'b0;

        do_reset();
        chk("rst_tos", 32'(tos), 32'h0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        chk("rst_hwm", 32'(hwm), 32'd0);

        for (int i = 1; i <= 4; i++) op(1'b1, 2'b01, 1'b1, 16'(i), 1'b0);
        chk("push4_tos", 32'(tos), 32'h4);
        chk("push4_nos", 32'(nos), 32'h3);
        chk("push4_depth", 32'(depth), 32'd4);
        chk("push4_hwm", 32'(hwm), 32'd4);
        chk("push4_empty", 32'(empty), 32'd0);

        op(1'b1, 2'b10, 1'b0, 16'h0, 1'b0);
        chk("pop2_tos", 32'(tos), 32'h2);
        chk("pop2_nos", 32'(nos), 32'h1);
        chk("pop2_depth", 32'(depth), 32'd2);

        op(1'b1, 2'b11, 1'b0, 16'h0, 1'b0);
        chk("pop1_tos", 32'(tos), 32'h1);
        chk("pop1_depth", 32'(depth), 32'd1);
        chk("pop1_unf", 32'(unf), 32'd0);
        chk("pop1_hwm", 32'(hwm), 32'd4);

        // Paused push: nothing moves, nos still reads storage[1] which holds 0.
        op(1'b0, 2'b01, 1'b1, 16'hBEEF, 1'b0);
        chk("pause_tos", 32'(tos), 32'h1);
        chk("pause_depth", 32'(depth), 32'd1);
        chk("pause_nos", 32'(nos), 32'h0);
        chk("pause_hwm", 32'(hwm), 32'd4);

        op(1'b1, 2'b00, 1'b1, 16'h1234, 1'b0);
        chk("ld_tos", 32'(tos), 32'h1234);
        chk("ld_depth", 32'(depth), 32'd1);
        op(1'b1, 2'b00, 1'b0, 16'h5678, 1'b0);
        chk("hold_tos", 32'(tos), 32'h1234);

        // Fill to 16, then overflow with a 17th push.
        do_reset();
        for (int i = 1; i <= 15; i++) op(1'b1, 2'b01, 1'b1, 16'(16'h100 + i), 1'b0);
        chk("fill15_full", 32'(full), 32'd0);
        chk("fill15_depth", 32'(depth), 32'd15);
        op(1'b1, 2'b01, 1'b1, 16'h110, 1'b0);
        chk("fill16_full", 32'(full), 32'd1);
        chk("fill16_depth", 32'(depth), 32'd16);
        chk("fill16_ovf", 32'(ovf), 32'd0);
        op(1'b1, 2'b01, 1'b1, 16'h111, 1'b0);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_depth", 32'(depth), 32'd16);
        chk("ovf_hwm", 32'(hwm), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_tos", 32'(tos), 32'h111);
        chk("ovf_nos", 32'(nos), 32'h110);
        op(1'b1, 2'b10, 1'b0, 16'h0, 1'b0);
        chk("wrap_pop2_tos", 32'(tos), 32'h10F);
        chk("wrap_pop2_nos", 32'(nos), 32'h10E);
        chk("wrap_pop2_depth", 32'(depth), 32'd14);
        chk("wrap_pop2_hwm", 32'(hwm), 32'd16);
        chk("wrap_pop2_ovf", 32'(ovf), 32'd1);
        op(1'b0, 2'b00, 1'b0, 16'h0, 1'b1);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_ovf_depth", 32'(depth), 32'd14);

        // Underflow and clear interaction.
        do_reset();
        op(1'b1, 2'b11, 1'b0, 16'h0, 1'b0);
        chk("unf_pop1_flag", 32'(unf), 32'd1);
        chk("unf_pop1_depth", 32'(depth), 32'd0);
        chk("unf_pop1_empty", 32'(empty), 32'd1);
        op(1'b1, 2'b00, 1'b0, 16'h0, 1'b1);
        chk("unf_clr", 32'(unf), 32'd0);
        op(1'b1, 2'b01, 1'b1, 16'hAAAA, 1'b0);
        chk("unf_push_depth", 32'(depth), 32'd1);
        op(1'b1, 2'b10, 1'b0, 16'h0, 1'b1);
        chk("unf_pop2_clr_flag", 32'(unf), 32'd1);
        chk("unf_pop2_depth", 32'(depth), 32'd0);
        chk("unf_pop2_hwm", 32'(hwm), 32'd1);

        // Reset mid-sequence at depth 5 with ovf set.
        do_reset();
        for (int i = 1; i <= 17; i++) op(1'b1, 2'b01, 1'b1, 16'(i), 1'b0);
        for (int i = 0; i < 5; i++) op(1'b1, 2'b10, 1'b0, 16'h0, 1'b0);
        op(1'b1, 2'b11, 1'b0, 16'h0, 1'b0);
        chk("pre_rst_depth", 32'(depth), 32'd5);
        chk("pre_rst_ovf", 32'(ovf), 32'd1);
        reset = 1'b1; en = 1'b1; delta = 2'b01; tos_we = 1'b1; wd = 16'hBEEF;
        step();
        reset = 1'b0; en = 1'b0; delta = 2'b00; tos_we = 1'b0;
        chk("mid_rst_tos", 32'(tos), 32'h0);
        chk("mid_rst_depth", 32'(depth), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_hwm", 32'(hwm), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
